pipe_skid_stage: RTL and testbench
==================================

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 The block SHALL have the parameter PAYLOAD_W, default 104, meaning the width of the opaque per-instruction payload (pc, rs2 data, control fields, alu data).
REQ-002 The block SHALL have the parameter NOP_INSN, default 32'h00000013, meaning the instruction word presented when the stage holds no valid entry.
REQ-003 The block SHALL have the parameter CNT_W, default 16, meaning the width of the performance counters.
REQ-004 The block SHALL use one clock; reset is synchronous and active-low.
REQ-005 i_clk  in  1  rising-edge clock.
REQ-006 i_rst_n  in  1  synchronous active-low reset.
REQ-007 i_flush  in  1  discard all held entries.
REQ-008 i_vld  in  1  upstream entry valid.
REQ-009 o_rdy  out  1  stage can accept an entry this cycle.
REQ-010 i_insn  in  32  upstream instruction word.
REQ-011 i_payload  in  PAYLOAD_W  upstream payload.
REQ-012 o_vld  out  1  downstream entry valid.
REQ-013 i_rdy  in  1  downstream accepts this cycle.
REQ-014 o_insn  out  32  head instruction word.
REQ-015 o_payload  out  PAYLOAD_W  head payload.
REQ-016 o_count  out  2  entries held (0..2).
REQ-017 o_stall_cnt  out  CNT_W  cycles with o_vld=1 and i_rdy=0 (PIPE_SKID_STAGE_PERF_EN only).
REQ-018 o_flush_cnt  out  CNT_W  flushes that discarded at least one entry (PIPE_SKID_STAGE_PERF_EN only).

Function
REQ-019 The block SHALL hold up to two entries: a head register driving the outputs, and a skid register.
REQ-020 The block SHALL have states EMPTY (0 entries), ONE (head valid), and FULL (head and skid valid); o_count SHALL equal the state encoding 0/1/2.
REQ-021 The block SHALL define push = i_vld and o_rdy, and pop = o_vld and i_rdy.
REQ-022 The block SHALL drive o_rdy = (state != FULL) as a registered signal with no combinational path from i_rdy.
REQ-023 The block SHALL drive o_vld = (state != EMPTY).
REQ-024 The block SHALL have a latency of one cycle: an entry pushed into EMPTY appears on the outputs in the following cycle.
REQ-025 EMPTY transitions: push -> ONE (input to head); else remain EMPTY.
REQ-026 ONE transitions: push and pop -> ONE (input to head); push only -> FULL (input to skid); pop only -> EMPTY; neither -> ONE.
REQ-027 FULL transitions: pop -> ONE (skid to head); else remain FULL; push is impossible because o_rdy=0.
REQ-028 Entries SHALL leave in acceptance order, and a held entry SHALL not change while it is not popped.
REQ-029 When o_vld=0, o_insn SHALL equal NOP_INSN and o_payload SHALL be all zero.
REQ-030 i_flush SHALL take effect at the next edge: state -> EMPTY and head/skid cleared (head instruction = NOP_INSN).
REQ-031 i_flush SHALL have priority over a simultaneous push or pop; a same-cycle push is dropped and a same-cycle pop still completes downstream.
REQ-032 i_vld SHALL be ignored while o_rdy=0; i_insn and i_payload SHALL be don't-care when i_vld=0.

Reset
REQ-033 While i_rst_n=0 at an edge, the block SHALL reset to: state EMPTY, o_vld=0, o_rdy=1, o_count=0, o_insn=NOP_INSN, o_payload=0, and both counters 0.
REQ-034 Reset SHALL override flush, push and pop in the same cycle, and any held entries SHALL be lost.

Configuration
REQ-035 With the macro PIPE_SKID_STAGE_PERF_EN defined, o_stall_cnt SHALL increment on each stall cycle, o_flush_cnt SHALL increment on each flush with o_count != 0, and both SHALL saturate at all-ones.
REQ-036 Without PIPE_SKID_STAGE_PERF_EN, the counter logic SHALL be absent, and o_stall_cnt and o_flush_cnt SHALL be tied to zero; all other behaviour SHALL be identical.

Verification
REQ-037 Bench scenario, pass-through: i_rdy=1, push insn A1 then A2 on consecutive cycles -> o_insn=A1 then A2, one cycle after each push, with o_count=1 throughout.
REQ-038 Bench scenario, skid fill: i_rdy=0, push B1 then B2 -> o_count=2, o_rdy=0; then i_vld=1 with B3 is ignored; then i_rdy=1 for 2 cycles -> B1, B2 out, o_count=0.
REQ-039 Bench scenario, flush in FULL: with the stage FULL, assert i_flush together with i_vld for C1 -> next cycle o_vld=0, o_insn=32'h00000013, o_payload=0, and C1 never appears.
REQ-040 Bench scenario, simultaneous events in ONE: push D2 and pop D1 in the same cycle -> o_insn=D2, o_count=1, and no bubble.
REQ-041 Bench scenario, reset mid-operation: with the stage FULL, drive i_rst_n=0 for one cycle -> o_count=0, o_rdy=1, o_insn=32'h00000013, and counters 0.
REQ-042 Bench scenario, PERF build with CNT_W=4: 20 stall cycles -> o_stall_cnt=15 (saturated); 3 flushes with o_count != 0 and 1 flush with o_count=0 -> o_flush_cnt=3.

Source files
------------

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: two-entry skid buffer with registered ready; optional counters under PIPE_SKID_STAGE_PERF_EN
module pipe_skid_stage #(
  parameter int          PAYLOAD_W = 104,
  parameter logic [31:0] NOP_INSN  = 32'h00000013,
  parameter int          CNT_W     = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_flush,
  input  logic                 i_vld,
  output logic                 o_rdy,
  input  logic [31:0]          i_insn,
  input  logic [PAYLOAD_W-1:0] i_payload,
  output logic                 o_vld,
  input  logic                 i_rdy,
  output logic [31:0]          o_insn,
  output logic [PAYLOAD_W-1:0] o_payload,
  output logic [1:0]           o_count,
  output logic [CNT_W-1:0]     o_stall_cnt,
  output logic [CNT_W-1:0]     o_flush_cnt
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t                 state_q, state_d;
  logic                   rdy_q, rdy_d;
  logic [31:0]            head_insn_q, head_insn_d, skid_insn_q, skid_insn_d;
  logic [PAYLOAD_W-1:0]   head_pay_q, head_pay_d, skid_pay_q, skid_pay_d;
  logic                   push, pop;
  assign o_vld     = state_q != EMPTY;
  assign o_rdy     = rdy_q;
  assign push      = i_vld & rdy_q;
  assign pop       = o_vld & i_rdy;
  assign o_count   = state_q;
  assign o_insn    = o_vld ? head_insn_q : NOP_INSN;
  assign o_payload = o_vld ? head_pay_q : '0;
  // next state and entry movement; flush wins over push/pop, ready follows the next state
  always_comb begin
    state_d     = state_q;
    head_insn_d = head_insn_q;
    head_pay_d  = head_pay_q;
    skid_insn_d = skid_insn_q;
    skid_pay_d  = skid_pay_q;
    if (i_flush) begin
      state_d     = EMPTY;
      head_insn_d = NOP_INSN;
      head_pay_d  = '0;
      skid_insn_d = NOP_INSN;
      skid_pay_d  = '0;
    end else begin
      case (state_q)
        EMPTY: if (push) begin
          state_d     = ONE;
          head_insn_d = i_insn;
          head_pay_d  = i_payload;
        end
        ONE: if (push && pop) begin
          head_insn_d = i_insn;
          head_pay_d  = i_payload;
        end else if (push) begin
          state_d     = FULL;
          skid_insn_d = i_insn;
          skid_pay_d  = i_payload;
        end else if (pop) begin
          state_d     = EMPTY;
          head_insn_d = NOP_INSN;
          head_pay_d  = '0;
        end
        FULL: if (pop) begin
          state_d     = ONE;
          head_insn_d = skid_insn_q;
          head_pay_d  = skid_pay_q;
          skid_insn_d = NOP_INSN;
          skid_pay_d  = '0;
        end
        default: state_d = EMPTY;
      endcase
    end
    rdy_d = state_d != FULL;
  end
  // state, ready and entry registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= EMPTY;
      rdy_q       <= 1'b1;
      head_insn_q <= NOP_INSN;
      head_pay_q  <= '0;
      skid_insn_q <= NOP_INSN;
      skid_pay_q  <= '0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= rdy_d;
      head_insn_q <= head_insn_d;
      head_pay_q  <= head_pay_d;
      skid_insn_q <= skid_insn_d;
      skid_pay_q  <= skid_pay_d;
    end
  end
`ifdef PIPE_SKID_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;
  // saturating counts of stalled cycles and of flushes that discarded entries
  always_comb begin
    stall_cnt_d = (o_vld && !i_rdy && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = (i_flush && o_vld && flush_cnt_q != '1) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end
  // counter registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
`else
  assign o_stall_cnt = '0;
  assign o_flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: directed scenarios with a queue scoreboard checking every downstream pop
module tb_pipe_skid_stage;
  localparam int PW = 104;
  localparam int CW = 4;
  localparam logic [31:0] NOP = 32'h00000013;
`ifdef PIPE_SKID_STAGE_PERF_EN
  localparam int EXP_STALL = 15;
  localparam int EXP_FLUSH = 3;
`else
  localparam int EXP_STALL = 0;
  localparam int EXP_FLUSH = 0;
`endif
  logic          clk = 0, rst_n = 0, flush = 0, vld = 0, rdy = 0;
  logic [31:0]   insn = 0;
  logic [PW-1:0] payload = 0;
  logic          o_rdy, o_vld;
  logic [31:0]   o_insn;
  logic [PW-1:0] o_payload;
  logic [1:0]    o_count;
  logic [CW-1:0] o_stall_cnt, o_flush_cnt;
  int            checks = 0, failures = 0;
  logic [31:0]   q[$];

  pipe_skid_stage #(.PAYLOAD_W(PW), .NOP_INSN(NOP), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_vld(vld), .o_rdy(o_rdy),
    .i_insn(insn), .i_payload(payload), .o_vld(o_vld), .i_rdy(rdy),
    .o_insn(o_insn), .o_payload(o_payload), .o_count(o_count),
    .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] pay(input logic [31:0] w);
    return {w, ~w, w, 8'h5A};
  endfunction

  task automatic chk(input string n, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] w, input logic r, input logic f);
    vld = v; insn = w; payload = pay(w); rdy = r; flush = f;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: record accepted entries, compare each pop against the oldest
  always @(negedge clk) begin
    if (!rst_n) q.delete();
    else begin
      if (o_vld && rdy) begin
        if (q.size() == 0) chk("pop_unexpected", o_insn, 0);
        else begin
          logic [31:0] e;
          e = q.pop_front();
          chk("pop_insn", o_insn, e);
          chk("pop_payload", o_payload, pay(e));
        end
      end
      if (flush) q.delete();
      else if (vld && o_rdy) q.push_back(insn);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    drive(0, 0, 0, 0);
    step(); step();
    chk("rst_count", o_count, 0);
    chk("rst_rdy", o_rdy, 1);
    chk("rst_vld", o_vld, 0);
    chk("rst_insn", o_insn, NOP);
    chk("rst_payload", o_payload, 0);
    chk("rst_stall", o_stall_cnt, 0);
    chk("rst_flushcnt", o_flush_cnt, 0);
    rst_n = 1;
    // pass-through
    drive(1, 32'hA000_0001, 1, 0); step();
    chk("a1_insn", o_insn, 32'hA000_0001); chk("a1_count", o_count, 1);
    drive(1, 32'hA000_0002, 1, 0); step();
    chk("a2_insn", o_insn, 32'hA000_0002); chk("a2_count", o_count, 1);
    drive(0, 0, 1, 0); step();
    chk("a_empty", o_count, 0);
    // skid fill
    drive(1, 32'hB000_0001, 0, 0); step();
    chk("b1_count", o_count, 1);
    drive(1, 32'hB000_0002, 0, 0); step();
    chk("b2_count", o_count, 2); chk("b2_rdy", o_rdy, 0);
    drive(1, 32'hB000_0003, 0, 0); step();
    chk("b3_count", o_count, 2); chk("b3_head", o_insn, 32'hB000_0001);
    drive(0, 0, 1, 0); step();
    chk("b_out2", o_insn, 32'hB000_0002); chk("b_cnt1", o_count, 1); chk("b_rdy", o_rdy, 1);
    step();
    chk("b_empty", o_count, 0);
    // flush in FULL
    drive(1, 32'hC000_0001, 0, 0); step();
    drive(1, 32'hC000_0002, 0, 0); step();
    chk("c_full", o_count, 2);
    drive(1, 32'hC000_00C1, 0, 1); step();
    chk("c_vld", o_vld, 0); chk("c_insn", o_insn, NOP);
    chk("c_payload", o_payload, 0); chk("c_count", o_count, 0); chk("c_rdy", o_rdy, 1);
    drive(0, 0, 1, 0); step(); step();
    chk("c_stays_empty", o_vld, 0);
    // simultaneous push and pop in ONE
    drive(1, 32'hD000_0001, 1, 0); step();
    chk("d1_insn", o_insn, 32'hD000_0001);
    drive(1, 32'hD000_0002, 1, 0); step();
    chk("d2_insn", o_insn, 32'hD000_0002); chk("d2_count", o_count, 1); chk("d2_vld", o_vld, 1);
    drive(0, 0, 1, 0); step();
    chk("d_empty", o_count, 0);
    // flush in ONE with push and pop: pop completes, push dropped
    drive(1, 32'hE000_0001, 1, 0); step();
    drive(1, 32'hE000_0002, 1, 1); step();
    chk("e_count", o_count, 0); chk("e_vld", o_vld, 0);
    // reset mid-operation
    drive(1, 32'hF000_0001, 0, 0); step();
    drive(1, 32'hF000_0002, 0, 0); step();
    chk("f_full", o_count, 2);
    rst_n = 0;
    drive(1, 32'hF000_0003, 1, 1); step();
    chk("f_count", o_count, 0); chk("f_rdy", o_rdy, 1); chk("f_insn", o_insn, NOP);
    chk("f_stall", o_stall_cnt, 0); chk("f_flushcnt", o_flush_cnt, 0);
    rst_n = 1;
    // counters: 20 stall cycles, 3 flushes with entries and 1 with none
    drive(1, 32'h1000_0001, 0, 0); step();
    drive(0, 0, 0, 0);
    repeat (20) step();
    chk("stall_sat", o_stall_cnt, EXP_STALL);
    drive(0, 0, 0, 1); step();
    drive(1, 32'h1000_0002, 0, 0); step();
    drive(0, 0, 0, 1); step();
    drive(1, 32'h1000_0003, 0, 0); step();
    drive(0, 0, 0, 1); step();
    step();
    drive(0, 0, 0, 0); step();
    chk("flush_cnt", o_flush_cnt, EXP_FLUSH);
    chk("g_empty", o_count, 0);
    step();
    chk("q_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
